// File: rtl/ahb_master.sv
// ahb_master -- command-driven AHB-Lite master.
//
// Turns one command (read/write, SINGLE or INCR4, start address) into AHB-Lite
// transfers. Write beats are pulled from the client with wd_pop; read beats are
// returned on rd_data/rd_valid. Completion is signalled with a one-cycle done
// pulse, and err qualifies it when the slave answered with an ERROR response.
//
// Build option: define AHB_MASTER_BURST_EN to support INCR4 bursts. Without it,
// cmd_burst is ignored and every command is a SINGLE transfer.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_write, cmd_burst   direction (1 = write), burst select (1 = INCR4)
//   cmd_addr               start byte address
//   wdata, wd_pop          write beat source; wdata is taken when wd_pop = 1
//   rd_data, rd_valid      registered read beat and its one-cycle strobe
//   done, err              command completion pulse and error flag
//   HADDR ... HWDATA       AHB-Lite master outputs
//   HREADY, HRESP, HRDATA  AHB-Lite master inputs
module ahb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_burst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wd_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    // ADDR: address phases being issued (a data phase may overlap them)
    // LAST: only the final data phase is outstanding, HTRANS = IDLE
    // ERR2: second cycle of an ERROR response
    typedef enum logic [1:0] {IDLE, ADDR, LAST, ERR2} state_t;

    localparam logic [1:0]            TRANS_IDLE   = 2'b00;
    localparam logic [1:0]            TRANS_NONSEQ = 2'b10;
    localparam logic [1:0]            TRANS_SEQ    = 2'b11;
    localparam logic [2:0]            BURST_SINGLE = 3'b000;
    localparam logic [2:0]            BURST_INCR4  = 3'b011;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES   = ADDR_WIDTH'(4);

    state_t                state, state_nxt;
    logic [1:0]            beat_cnt;     // index of the address phase on the bus
    logic [1:0]            last_beat;    // 0 for SINGLE, 3 for INCR4
    logic                  data_active;  // a data phase overlaps the current cycle
    logic                  data_err;     // that data phase reports ERROR
    logic                  burst_sel;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  unused_bits;

`ifdef AHB_MASTER_BURST_EN
    assign burst_sel   = cmd_burst;
    assign unused_bits = ^cmd_addr[1:0];
`else
    assign burst_sel   = 1'b0;
    assign unused_bits = cmd_burst ^ (^cmd_addr[1:0]);
`endif

    // Word-align every command; INCR4 additionally aligns to the 16-byte
    // block so the four beats never wrap or cross a 1 KB boundary.
    assign start_addr = burst_sel ? {cmd_addr[ADDR_WIDTH-1:4], 4'h0}
                                  : {cmd_addr[ADDR_WIDTH-1:2], 2'b00};

    assign data_err = data_active && HRESP;
    assign HSIZE    = 3'b010;
    assign HPROT    = 4'b0011;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path leaves an output unassigned and
        // infers a latch.
        state_nxt = state;
        cmd_ready = 1'b0;
        wd_pop    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ADDR;
            end
            ADDR: begin
                if (data_err) begin
                    // The pending address phase is dropped, so no wd_pop.
                    state_nxt = HREADY ? IDLE : ERR2;
                end else if (HREADY) begin
                    wd_pop = HWRITE;
                    if (beat_cnt == last_beat) state_nxt = LAST;
                end
            end
            LAST: begin
                if (HRESP)       state_nxt = HREADY ? IDLE : ERR2;
                else if (HREADY) state_nxt = IDLE;
            end
            ERR2: begin
                if (HREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR       <= '0;
            HTRANS      <= TRANS_IDLE;
            HWRITE      <= 1'b0;
            HBURST      <= BURST_SINGLE;
            HWDATA      <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            beat_cnt    <= '0;
            last_beat   <= '0;
            data_active <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        HADDR       <= start_addr;
                        HTRANS      <= TRANS_NONSEQ;
                        HWRITE      <= cmd_write;
                        HBURST      <= burst_sel ? BURST_INCR4 : BURST_SINGLE;
                        last_beat   <= burst_sel ? 2'd3 : 2'd0;
                        beat_cnt    <= '0;
                        data_active <= 1'b0;
                    end
                end
                ADDR: begin
                    if (data_err) begin
                        HTRANS <= TRANS_IDLE;
                        if (HREADY) begin
                            done        <= 1'b1;
                            err         <= 1'b1;
                            data_active <= 1'b0;
                        end
                    end else if (HREADY) begin
                        // The address phase just completed becomes the next
                        // data phase; the previous data phase (if any) ends.
                        data_active <= 1'b1;
                        if (data_active && !HWRITE) begin
                            rd_data  <= HRDATA;
                            rd_valid <= 1'b1;
                        end
                        if (HWRITE) HWDATA <= wdata;
                        if (beat_cnt == last_beat) begin
                            HTRANS <= TRANS_IDLE;
                        end else begin
                            HTRANS   <= TRANS_SEQ;
                            HADDR    <= HADDR + BEAT_BYTES;
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                LAST: begin
                    if (HREADY) begin
                        done        <= 1'b1;
                        err         <= HRESP;
                        data_active <= 1'b0;
                        if (!HRESP && !HWRITE) begin
                            rd_data  <= HRDATA;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                ERR2: begin
                    if (HREADY) begin
                        done        <= 1'b1;
                        err         <= 1'b1;
                        data_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master -- self-checking bench for ahb_master.
// A scripted AHB-Lite slave supplies wait states, ERROR responses and random
// read data; a bus monitor records what the master did, and the expected
// addresses, beat counts, latencies and data are derived from the command
// with plain arithmetic. Adapts to builds with or without AHB_MASTER_BURST_EN.
module tb_ahb_master;

    localparam int DW = 32;
    localparam int AW = 32;

`ifdef AHB_MASTER_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_burst;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] wdata;
    logic          wd_pop;
    logic [DW-1:0] rd_data;
    logic          rd_valid, done, err;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA;
    logic          HREADY, HRESP;
    logic [DW-1:0] HRDATA;

    always #5 HCLK = ~HCLK;

    ahb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_addr(cmd_addr),
        .wdata(wdata), .wd_pop(wd_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Per-command observations
    logic [AW-1:0] obs_addr[$];
    logic [1:0]    obs_trans[$];
    logic [DW-1:0] obs_rd[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] wd_beat[4];
    logic [DW-1:0] last_hwdata;
    logic [2:0]    obs_burst;
    logic          err_seen, rdy_at_done;
    int            n_pop, n_done, done_cyc, hold_bad, hwdata_bad, write_bad;

    // Optional fixed data for directed cases
    bit            fix_wd_en, fix_rd_en;
    logic [DW-1:0] fix_wd, fix_rd;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one command and play the slave until two cycles after done.
    // wait_beat/err_beat are data-beat indices (0-based), -1 for none.
    task automatic run_cmd(input string name, input bit wr, input bit bst, input logic [AW-1:0] addr,
                           input int wait_beat, input int wait_n, input int err_beat);
        int nbeats, n_addr_exp, exp_done, exp_rdv, wait_left, err_stage, beat_idx, dp_beat;
        bit dp_active, prev_hold, has_err;
        logic [1:0]    prev_trans;
        logic [AW-1:0] prev_addr, base;

        nbeats  = (BURST_EN && bst) ? 4 : 1;
        base    = (nbeats == 4) ? (addr & ~32'hF) : (addr & ~32'h3);
        has_err = (err_beat >= 0) && (err_beat < nbeats);
        if (has_err) begin
            n_addr_exp = (err_beat + 1 < nbeats) ? err_beat + 1 : nbeats;
            exp_done   = err_beat + 4 + ((wait_beat >= 0 && wait_beat < err_beat) ? wait_n : 0);
            exp_rdv    = wr ? 0 : err_beat;
        end else begin
            n_addr_exp = nbeats;
            exp_done   = nbeats + 2 + ((wait_beat >= 0 && wait_beat < nbeats) ? wait_n : 0);
            exp_rdv    = wr ? 0 : nbeats;
        end

        obs_addr.delete(); obs_trans.delete(); obs_rd.delete(); exp_rd.delete();
        n_pop = 0; n_done = 0; done_cyc = -1; hold_bad = 0; hwdata_bad = 0; write_bad = 0;
        err_seen = 1'b0; rdy_at_done = 1'b0; obs_burst = 3'bxxx;
        wait_left = wait_n; err_stage = 0; beat_idx = 0; dp_beat = 0;
        dp_active = 1'b0; prev_hold = 1'b0; prev_trans = 2'b00; prev_addr = '0;

        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_burst = bst; cmd_addr = addr;
        HREADY = 1'b1; HRESP = 1'b0;
        #1 check({name, "/cmd_ready"}, cmd_ready, 1);

        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge HCLK);
            cmd_valid = 1'b0;
            wdata  = fix_wd_en ? fix_wd : $urandom;
            HRDATA = fix_rd_en ? fix_rd : $urandom;
            HREADY = 1'b1;
            HRESP  = 1'b0;
            if (dp_active) begin
                if (dp_beat == err_beat) begin
                    HRESP  = 1'b1;
                    HREADY = (err_stage != 0);
                    err_stage++;
                end else if (dp_beat == wait_beat && wait_left > 0) begin
                    HREADY = 1'b0;
                    wait_left--;
                end
            end
            #1;
            if (prev_hold && (HTRANS !== prev_trans || HADDR !== prev_addr)) hold_bad++;
            if (dp_active && wr && dp_beat < 4) begin
                if (HWDATA !== wd_beat[dp_beat]) hwdata_bad++;
                last_hwdata = HWDATA;
            end
            if (rd_valid) obs_rd.push_back(rd_data);
            if (done) begin
                n_done++;
                err_seen    = err;
                rdy_at_done = cmd_ready;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (wd_pop) begin
                n_pop++;
                if (beat_idx < 4) wd_beat[beat_idx] = wdata;
            end
            // What happens at the coming rising edge
            if (dp_active && HREADY) begin
                if (!HRESP && !wr) exp_rd.push_back(HRDATA);
                dp_active = 1'b0;
            end
            if (HTRANS[1] && HREADY) begin
                obs_addr.push_back(HADDR);
                obs_trans.push_back(HTRANS);
                if (HWRITE !== wr) write_bad++;
                if (beat_idx == 0) obs_burst = HBURST;
                dp_active = 1'b1;
                dp_beat   = beat_idx;
                beat_idx++;
            end
            prev_hold  = (HREADY == 1'b0) && (HRESP == 1'b0);
            prev_trans = HTRANS;
            prev_addr  = HADDR;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end

        check({name, "/done_count"}, n_done, 1);
        check({name, "/done_cycle"}, done_cyc, exp_done);
        check({name, "/err"}, err_seen, has_err);
        check({name, "/ready_at_done"}, rdy_at_done, 1);
        check({name, "/addr_phases"}, obs_addr.size(), n_addr_exp);
        for (int i = 0; i < n_addr_exp && i < obs_addr.size(); i++) begin
            check($sformatf("%s/haddr%0d", name, i), obs_addr[i], base + 32'(4 * i));
            check($sformatf("%s/htrans%0d", name, i), obs_trans[i], (i == 0) ? 2'b10 : 2'b11);
        end
        check({name, "/hburst"}, obs_burst, (nbeats == 4) ? 3'b011 : 3'b000);
        check({name, "/wd_pops"}, n_pop, wr ? n_addr_exp : 0);
        check({name, "/rd_valids"}, obs_rd.size(), exp_rdv);
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
            check($sformatf("%s/rd_data%0d", name, i), obs_rd[i], exp_rd[i]);
        check({name, "/hold_stable"}, hold_bad, 0);
        check({name, "/hwdata"}, hwdata_bad, 0);
        check({name, "/hwrite"}, write_bad, 0);
    endtask

    initial begin
        int n_rst_done, bad_idle;
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0; cmd_addr = '0;
        wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        fix_wd_en = 1'b0; fix_rd_en = 1'b0; fix_wd = '0; fix_rd = '0; last_hwdata = '0;

        // Reset values
        repeat (2) @(negedge HCLK);
        #1;
        check("reset/htrans", HTRANS, 2'b00);
        check("reset/haddr", HADDR, 0);
        check("reset/hwrite", HWRITE, 0);
        check("reset/hburst", HBURST, 0);
        check("reset/hwdata", HWDATA, 0);
        check("reset/rd_data", rd_data, 0);
        check("reset/flags", {rd_valid, wd_pop, done, err}, 4'b0000);
        check("hsize", HSIZE, 3'b010);
        check("hprot", HPROT, 4'b0011);
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1 check("reset/cmd_ready", cmd_ready, 1);

        // SINGLE write, unaligned address
        fix_wd_en = 1'b1; fix_wd = 32'hDEADBEEF;
        run_cmd("single_write", 1'b1, 1'b0, 32'h0000_1006, -1, 0, -1);
        if (obs_addr.size() > 0) check("single_write/haddr_1004", obs_addr[0], 32'h0000_1004);
        check("single_write/hwdata_deadbeef", last_hwdata, 32'hDEADBEEF);
        fix_wd_en = 1'b0;

        // SINGLE read, zero wait: done at cycle 3
        fix_rd_en = 1'b1; fix_rd = 32'h1234_5678;
        run_cmd("single_read", 1'b0, 1'b0, 32'h0000_0020, -1, 0, -1);
        if (obs_rd.size() > 0) check("single_read/rd_12345678", obs_rd[0], 32'h1234_5678);
        fix_rd_en = 1'b0;

        // INCR4 read with two wait cycles on the second beat
        run_cmd("incr4_read_wait", 1'b0, 1'b1, 32'h0000_0104, 1, 2, -1);
        // INCR4 write with ERROR on the second beat
        run_cmd("incr4_write_err", 1'b1, 1'b1, 32'h0000_0200, -1, 0, 1);
        // Burst request as a write (SINGLE when bursts are disabled)
        run_cmd("burst_write", 1'b1, 1'b1, 32'h0000_0344, 0, 1, -1);
        // Error on a SINGLE read and on the final INCR4 beat
        run_cmd("single_read_err", 1'b0, 1'b0, 32'h0000_0408, -1, 0, 0);
        run_cmd("incr4_read_err_last", 1'b0, 1'b1, 32'h0000_0500, 0, 1, 3);

        // Reset in the middle of a command
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_burst = 1'b1; cmd_addr = $urandom;
        HREADY = 1'b1; HRESP = 1'b0;
        n_rst_done = 0;
        for (int c = 1; c <= (BURST_EN ? 3 : 2); c++) begin
            @(negedge HCLK);
            cmd_valid = 1'b0;
            HRDATA = $urandom | 32'h1;
            #1 if (done) n_rst_done++;
        end
        #1 HRESETn = 1'b0;
        #1;
        check("midrst/htrans", HTRANS, 2'b00);
        check("midrst/haddr", HADDR, 0);
        check("midrst/hwrite_hburst", {HWRITE, HBURST}, 4'b0000);
        check("midrst/hwdata", HWDATA, 0);
        check("midrst/rd_data", rd_data, 0);
        check("midrst/flags", {rd_valid, wd_pop, done, err}, 4'b0000);
        check("midrst/no_done_before", n_rst_done, 0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        #1 check("midrst/cmd_ready", cmd_ready, 1);
        n_rst_done = 0; bad_idle = 0;
        repeat (4) begin
            @(negedge HCLK);
            #1;
            if (done) n_rst_done++;
            if (HTRANS !== 2'b00) bad_idle++;
        end
        check("midrst/no_done_after", n_rst_done, 0);
        check("midrst/bus_idle", bad_idle, 0);

        // Randomized commands
        for (int k = 0; k < 12; k++) begin
            bit  r_wr, r_bst;
            int  r_wb, r_wn, r_eb;
            r_wr  = 1'($urandom_range(0, 1));
            r_bst = 1'($urandom_range(0, 1));
            r_wb  = int'($urandom_range(0, 4)) - 1;
            r_wn  = int'($urandom_range(0, 3));
            r_eb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_cmd($sformatf("rand%0d", k), r_wr, r_bst, $urandom, r_wb, r_wn, r_eb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
